protocol_arbiter: RTL
=====================

# protocol_arbiter

Round-robin arbiter that shares one serial protocol channel (the 1-bit `in`/`dout` pair of the protocol FSM) among `N_REQ` requesters. A requester holds a level request and, once granted, owns the channel input bit until it drops the request or its hold budget expires. A forced idle cycle separates every two owners so the protocol FSM always returns to IDLE between transactions. The arbiter sits between the client blocks and the single protocol FSM instance.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `HOLD_MAX`, 8, maximum consecutive cycles one grant may last (≥2)
- `clk`  in  1  system clock, rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  level request per requester
- `req_bit`  in  N_REQ  serial data bit offered by each requester
- `ch_dout`  in  1  `dout` returned by the shared protocol FSM
- `ch_in`  out  1  drives the protocol FSM `in`
- `grant`  out  N_REQ  one-hot registered grant, all-zero when idle
- `rsp`  out  N_REQ  `ch_dout` routed to the current owner only
- `busy`  out  1  high whenever the state is not IDLE
- `timeout`  out  1  one-cycle pulse on a forced release

## Operation
- States: IDLE, GRANT, HOLD, RELEASE. Registers: state, `grant`, owner index `g`, round-robin pointer `ptr` (clog2(N_REQ) bits), hold counter `cnt` (clog2(HOLD_MAX+1) bits), `timeout`.
- **IDLE:**
  - If `req` != 0, select the first set bit scanning from `ptr` upward, wrapping modulo N_REQ.
  - Load `g` and one-hot `grant`, set `cnt`=1, go to GRANT. Otherwise stay in IDLE.
- **GRANT / HOLD:**
  - If `req[g]`=0 at the edge, go to RELEASE with `timeout`=0.
  - Else if `cnt`==HOLD_MAX, go to RELEASE with `timeout`=1.
  - Else increment `cnt`. GRANT always advances to HOLD.
- **RELEASE:**
  - `grant`=0.
  - `ptr` = (g+1) mod N_REQ.
  - Clear `cnt`.
  - Go to IDLE.
  - The `timeout` register is high only during this state.
- Combinational outputs:
  - `ch_in` = `req_bit[g]` when `grant` != 0, else 0.
  - `rsp[i]` = `ch_dout` & `grant[i]`.
  - `busy` = (state != IDLE).
- Requests from non-owners never preempt the current owner. Priority is re-evaluated only in IDLE.
- Reset values (asynchronous, immediate on `rstn` low):
  - State is IDLE.
  - `grant`, `ptr`, `cnt`, `g`, `timeout` are all 0.
  - Hence `ch_in`, `rsp` and `busy` are 0.

## Timing
- Request latency:
  - If `req[i]` is high before edge k while in IDLE, `grant[i]` is high after edge k.
  - `ch_in` follows `req_bit[i]` combinationally from that point.
- Grant length:
  - 1 to HOLD_MAX cycles.
  - With `req[g]` held high continuously, the grant is exactly HOLD_MAX cycles.
- Release:
  - A `req[g]` drop sampled at edge m clears `grant` after edge m.
  - RELEASE lasts exactly one cycle, then IDLE lasts at least one cycle. The minimum gap between two grants is 2 cycles (RELEASE + IDLE).
- Throughput: under continuous contention the period per owner is HOLD_MAX+2 cycles.
- Simultaneous events:
  - Drop and budget expiry on the same edge count as a voluntary release, so `timeout`=0.
  - A new request arriving during RELEASE is evaluated in IDLE.
- Reset mid-operation:
  - `grant` and `ch_in` fall without waiting for a clock edge.
  - After `rstn` rises, arbitration restarts at `ptr`=0.

## Test plan
- Hold reset with `req`=4'hF for 3 cycles -> `grant`=0, `ch_in`=0, `busy`=0, `timeout`=0 throughout. Release reset -> `grant`=4'b0001 after the first edge.
- Set `req`=4'b0010, `req_bit`=4'b0010 for 5 cycles, then drop it -> `grant`=4'b0010 for 5 cycles with `ch_in`=1. Then one cycle of RELEASE with `busy`=1 and `grant`=0, then IDLE with `busy`=0. `timeout` never pulses.
- Hold `req`=4'hF constantly with HOLD_MAX=8 -> `grant` sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles and the grants are separated by 2 idle-grant cycles. `timeout` pulses once per release.
- Rotation: serve requester 0, then apply `req`=4'b0101 -> next grant is 4'b0100 (`ptr`=1), then 4'b0001.
- Drive `ch_dout`=1 while requester 2 owns the channel -> `rsp`=4'b0100. In IDLE, `rsp`=0 regardless of `ch_dout`.
- Assert `rstn` low mid-HOLD while requester 3 owns the channel -> `grant`=0 immediately with no clock edge. After reset, `req`=4'b1001 -> grant 4'b0001.

Source files
------------

// File: rtl/protocol_arbiter.sv
// protocol_arbiter: round-robin owner selection for one shared serial protocol
// channel. Each grant is followed by a forced RELEASE + IDLE gap so the downstream
// protocol FSM always returns to IDLE between owners.
module protocol_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_bit,
    input  logic             ch_dout,
    output logic             ch_in,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] rsp,
    output logic             busy,
    output logic             timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [PW:0]   NREQ_W = (PW + 1)'(N_REQ);
    localparam logic [CW-1:0] HOLD_W = CW'(HOLD_MAX);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLD, ST_RELEASE} state_t;

    state_t          state;
    logic [PW-1:0]   g;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic [2*N_REQ-1:0] req2;
    logic [N_REQ-1:0]   rot;
    logic [PW:0]        off;
    logic [PW:0]        sum;
    logic [PW-1:0]      sel;
    logic [PW:0]        ginc;
    logic [PW-1:0]      gnext;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        req2 = {req, req} >> ptr;
        rot  = req2[N_REQ-1:0];
        off  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = (PW + 1)'(j);
        end
        sum   = {1'b0, ptr} + off;
        sel   = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);
        ginc  = {1'b0, g} + (PW + 1)'(1);
        gnext = (ginc == NREQ_W) ? '0 : ginc[PW-1:0];
    end

    // Arbitration FSM; grant and timeout are registered outputs of this block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            grant   <= '0;
            g       <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        g     <= sel;
                        grant <= ONE << sel;
                        cnt   <= CW'(1);
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT, ST_HOLD: begin
                    // A drop wins over budget expiry, so simultaneous events are voluntary.
                    if (!req[g]) begin
                        grant   <= '0;
                        timeout <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (cnt == HOLD_W) begin
                        grant   <= '0;
                        timeout <= 1'b1;
                        state   <= ST_RELEASE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        state <= ST_HOLD;
                    end
                end
                ST_RELEASE: begin
                    grant   <= '0;
                    ptr     <= gnext;
                    cnt     <= '0;
                    timeout <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Channel input follows the owner's data bit only while a grant is live.
    assign ch_in = (|grant) & req_bit[g];
    assign busy  = (state != ST_IDLE);

    // Response routing: each lane sees ch_dout only while it owns the channel.
    for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
        assign rsp[i] = ch_dout & grant[i];
    end

endmodule
